// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared types and helpers for the programmable sequence
//                detector (state encoding, length-width and mask helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    // Widest pattern the helpers support (MAX_LEN upper bound).
    localparam int c_MASK_W = 16;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    function automatic logic [c_MASK_W-1:0] len_mask(input logic [4:0] len);
        logic [c_MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < c_MASK_W; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_ctrl_if
//  Description : Host configuration, serial bit stream and status bundle of
//                the sequence detector controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_ctrl_if #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = seq_det_pkg::calc_len_w(MAX_LEN)
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               bit_valid;
    logic               bit_in;
    logic               clr_count;
    logic               armed;
    logic               match;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap,
        output bit_valid, bit_in, clr_count,
        input  cfg_ready, cfg_err, armed, match, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap,
        input  bit_valid, bit_in, clr_count,
        output cfg_ready, cfg_err, armed, match, match_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_core
//  Description : Bit history, fill tracking and masked pattern compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               bit_stb,
    input  wire logic               clear,
    input  wire logic [LEN_W-1:0]   len,
    input  wire logic               overlap,
    input  wire logic [MAX_LEN-1:0] pattern,
    input  wire logic               bit_in,
    output logic                    hit
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_inc;

    assign w_cand     = {r_hist[MAX_LEN-2:0], bit_in};
    assign w_mask     = MAX_LEN'(len_mask(5'(len)));
    assign w_fill_inc = r_fill + LEN_W'(1);

    // fill gates the compare so stale history never produces a hit
    assign hit = bit_stb && (w_fill_inc >= len) &&
                 (((w_cand ^ pattern) & w_mask) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (bit_stb) begin
            r_hist <= w_cand;
            if (hit && !overlap)
                r_fill <= '0;
            else if (w_fill_inc > len)
                r_fill <= len;
            else
                r_fill <= w_fill_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_ctrl
//  Description : Programmable serial pattern detector: config handshake,
//                IDLE/LOAD/RUN sequencing and saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    seq_detect_ctrl_if.slave  bus
);

    localparam int LEN_W = calc_len_w(MAX_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_cfg_err;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;

    logic w_cfg_ready;
    logic w_armed;
    logic w_len_ok;
    logic w_cfg_acc;
    logic w_cfg_load;
    logic w_bit_stb;
    logic w_core_clr;
    logic w_hit;

    assign w_len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    assign w_cfg_acc  = bus.cfg_valid && w_cfg_ready;
    assign w_cfg_load = w_cfg_acc && w_len_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_ready = 1'b1;
        w_armed     = 1'b0;
        w_bit_stb   = 1'b0;
        w_core_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_load) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_cfg_ready = 1'b0;
                w_core_clr  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_armed = 1'b1;
                // a reconfiguration in the same cycle discards the bit
                w_bit_stb = bus.bit_valid && !w_cfg_load;
                if (w_cfg_load) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_cfg_err <= 1'b0;
            r_match   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_cfg_acc && !w_len_ok;
            r_match   <= w_hit;
            if (w_cfg_load) begin
                r_pattern <= bus.cfg_pattern;
                r_len     <= bus.cfg_len;
                r_overlap <= bus.cfg_overlap;
            end
            if (bus.clr_count)
                r_count <= '0;
            else if (w_hit && (r_count != '1))
                r_count <= r_count + CNT_W'(1);
        end
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .bit_stb (w_bit_stb),
        .clear   (w_core_clr),
        .len     (r_len),
        .overlap (r_overlap),
        .pattern (r_pattern),
        .bit_in  (bus.bit_in),
        .hit     (w_hit)
    );

    assign bus.cfg_ready   = w_cfg_ready;
    assign bus.armed       = w_armed;
    assign bus.cfg_err     = r_cfg_err;
    assign bus.match       = r_match;
    assign bus.match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_ctrl
//  Description : Self-checking bench for seq_detect_ctrl with a queue-based
//                reference model of the detector rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_MAX = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus ();
    seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus2 ();

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit       m_loading, m_armed, m_ovl, e_match, e_err;
    bit [7:0] m_pat;
    int       m_len, m_avail, m_count;
    bit       m_bits[$];

    function automatic logic [11:0] obs1();
        return {bus.match, bus.cfg_err, bus.armed, bus.cfg_ready, bus.match_count};
    endfunction

    function automatic logic [11:0] exp1();
        return {e_match, e_err, m_armed, ~m_loading, 8'(m_count)};
    endfunction

    task automatic model_reset();
        m_loading = 0; m_armed = 0; m_ovl = 0; m_pat = '0; m_len = 0;
        m_avail = 0; m_count = 0; e_match = 0; e_err = 0;
        m_bits.delete();
    endtask

    task automatic idle_inputs();
        bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus.bit_valid = 0; bus.bit_in = 0; bus.clr_count = 0;
        bus2.cfg_valid = 0; bus2.cfg_pattern = '0; bus2.cfg_len = '0; bus2.cfg_overlap = 0;
        bus2.bit_valid = 0; bus2.bit_in = 0; bus2.clr_count = 0;
    endtask

    // Drive one clock of stimulus on dut and advance the model by the same cycle.
    task automatic cycle(input bit cv, input bit [7:0] pat, input int len, input bit ovl,
                         input bit bv, input bit b, input bit clr);
        bit acc, legal, hit;
        bus.cfg_valid = cv; bus.cfg_pattern = pat; bus.cfg_len = 4'(len);
        bus.cfg_overlap = ovl; bus.bit_valid = bv; bus.bit_in = b; bus.clr_count = clr;
        acc   = cv && !m_loading;
        legal = (len >= 1) && (len <= MAX_LEN);
        hit   = 0;
        if (m_armed && bv && !(acc && legal)) begin
            m_bits.push_back(b);
            if (m_bits.size() > 16) void'(m_bits.pop_front());
            m_avail++;
            if (m_avail >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
            end
            if (hit && !m_ovl) m_avail = 0;
        end
        if (clr) m_count = 0;
        else if (hit && m_count < CNT_MAX) m_count++;
        e_match = hit;
        e_err   = acc && !legal;
        if (m_loading) begin
            m_loading = 0; m_armed = 1; m_avail = 0; m_bits.delete();
        end else if (acc && legal) begin
            m_loading = 1; m_armed = 0; m_pat = pat; m_len = len; m_ovl = ovl;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs1() !== 12'h100) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs1(), 12'h100);
        end
        checks++;
        if ({bus2.match, bus2.cfg_err, bus2.armed, bus2.cfg_ready, bus2.match_count} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_state_cnt2: got %b want 000100",
                     {bus2.match, bus2.cfg_err, bus2.armed, bus2.cfg_ready, bus2.match_count});
        end
    endtask

    task automatic run_101(input bit ovl, input logic [4:0] want, input int want_cnt, input string name);
        logic [4:0] got;
        bit [4:0]   bits;
        bits = 5'b10101;
        got  = '0;
        cycle(1, 8'b101, 3, ovl, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 4; i >= 0; i--) begin
            cycle(0, 0, 0, 0, 1, bits[i], 0);
            got = {got[3:0], bus.match};
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL %s_bit%0d: got %h want %h", name, 5 - i, obs1(), exp1());
            end
        end
        checks++;
        if (got !== want || bus.match_count !== 8'(want_cnt)) begin
            errors++;
            $display("FAIL %s_summary: matches %b count %0d want %b count %0d",
                     name, got, bus.match_count, want, want_cnt);
        end
    endtask

    task automatic test_overlap();
        run_101(1'b1, 5'b00101, 2, "overlap");
    endtask

    task automatic test_nonoverlap();
        run_101(1'b0, 5'b00100, 1, "nonoverlap");
    endtask

    task automatic test_illegal();
        int lens[2] = '{0, MAX_LEN + 1};
        foreach (lens[k]) begin
            cycle(1, 8'hA5, lens[k], 1, 0, 0, 0);
            checks++;
            if (bus.cfg_err !== 1'b1 || bus.armed !== 1'b1 || bus.cfg_ready !== 1'b1 ||
                obs1() !== exp1()) begin
                errors++;
                $display("FAIL illegal_len%0d: got %h want err/armed/ready set, model %h",
                         lens[k], obs1(), exp1());
            end
            cycle(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (bus.cfg_err !== 1'b0 || obs1() !== exp1()) begin
                errors++;
                $display("FAIL illegal_len%0d_after: got %h want %h", lens[k], obs1(), exp1());
            end
        end
    endtask

    task automatic test_reconfig();
        bit [4:0]   pre;
        bit [3:0]   post;
        logic [3:0] got;
        pre  = 5'b10110;
        post = 4'b1100;
        got  = '0;
        cycle(1, 8'b101, 3, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 4; i >= 0; i--) cycle(0, 0, 0, 0, 1, pre[i], 0);
        // this bit would complete 101 if it were not discarded
        cycle(1, 8'b1100, 4, 0, 1, 1, 0);
        checks++;
        if (bus.match !== 1'b0 || bus.cfg_ready !== 1'b0 || obs1() !== exp1()) begin
            errors++;
            $display("FAIL reconfig_drop: got %h want %h", obs1(), exp1());
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            cycle(0, 0, 0, 0, 1, post[i], 0);
            got = {got[2:0], bus.match};
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL reconfig_bit%0d: got %h want %h", 4 - i, obs1(), exp1());
            end
        end
        checks++;
        if (got !== 4'b0001 || bus.match_count !== 8'd2) begin
            errors++;
            $display("FAIL reconfig_summary: matches %b count %0d want 0001 count 2",
                     got, bus.match_count);
        end
    endtask

    task automatic test_saturate();
        bus2.cfg_valid = 1; bus2.cfg_pattern = 8'b1; bus2.cfg_len = 4'd1; bus2.cfg_overlap = 1;
        @(posedge clk); #1;
        bus2.cfg_valid = 0;
        @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) begin
            bus2.bit_valid = 1; bus2.bit_in = 1;
            @(posedge clk); #1;
            checks++;
            if (bus2.match !== 1'b1 || bus2.match_count !== 2'((i > 3) ? 3 : i)) begin
                errors++;
                $display("FAIL saturate_bit%0d: match %b count %0d want 1 count %0d",
                         i, bus2.match, bus2.match_count, (i > 3) ? 3 : i);
            end
        end
        bus2.clr_count = 1;
        @(posedge clk); #1;
        checks++;
        if (bus2.match !== 1'b1 || bus2.match_count !== 2'd0) begin
            errors++;
            $display("FAIL saturate_clr: match %b count %0d want 1 count 0",
                     bus2.match, bus2.match_count);
        end
        bus2.clr_count = 0; bus2.bit_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (bus2.match !== 1'b0 || bus2.match_count !== 2'd0) begin
            errors++;
            $display("FAIL saturate_idle: match %b count %0d want 0 count 0",
                     bus2.match, bus2.match_count);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 8'b101, 3, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        bus.bit_valid = 1; bus.bit_in = 1;
        #2 reset = 1;
        #1;
        checks++;
        if (obs1() !== 12'h100) begin
            errors++;
            $display("FAIL reset_mid_async: got %h want %h", obs1(), 12'h100);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.match !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nomatch: got %b want 0", bus.match);
        end
        reset = 0;
        model_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1, (i != 1), 0);
            checks++;
            if (obs1() !== exp1() || bus.match !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after%0d: got %h want %h", i, obs1(), exp1());
            end
        end
    endtask

    task automatic test_random();
        bit       cv, ovl, bv, b, clr;
        bit [7:0] pat;
        int       len;
        for (int n = 0; n < 600; n++) begin
            cv  = ($urandom_range(0, 11) == 0);
            pat = 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 15);
            else if ($urandom_range(0, 3) == 0)
                len = $urandom_range(1, MAX_LEN);
            else
                len = $urandom_range(1, 3);
            ovl = 1'($urandom);
            bv  = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom);
            clr = ($urandom_range(0, 59) == 0);
            cycle(cv, pat, len, ovl, bv, b, clr);
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL random_cyc%0d: got %h want %h", n, obs1(), exp1());
            end
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_illegal();
        test_reconfig();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
